// File: rtl/key_debounce_multi.sv
// rtl/key_debounce_multi.sv - multi-channel key synchroniser, debouncer and press/release/long-press pulser
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   key_in       raw asynchronous key pins, NUM_KEYS wide
//   key_level    debounced logical state per key, 1 = pressed regardless of pin polarity
//   key_press    one-cycle pulse when key_level rises
//   key_release  one-cycle pulse when key_level falls
//   key_long     one-cycle pulse once per press after LONG_MS of continuous hold (tied 0 when LONG_MS = 0)

module key_debounce_multi #(
  parameter int CLK_FREQ_HZ = 25_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int NUM_KEYS    = 4,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long
);

  localparam int CYC_PER_MS  = CLK_FREQ_HZ / 1000;
  localparam int DB_CYCLES   = CYC_PER_MS * DEBOUNCE_MS;
  localparam int LONG_CYCLES = CYC_PER_MS * LONG_MS;
  localparam int DB_W        = $clog2(DB_CYCLES + 1);
  localparam int LONG_W      = (LONG_CYCLES > 0) ? $clog2(LONG_CYCLES + 1) : 1;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  // Raw pin value of an unpressed key; also the xor mask that turns a pin into "pressed".
  localparam logic IDLE_RAW = (ACTIVE_LOW != 0);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    logic [1:0]      sync_q;
    logic            key_sync;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            release_q, release_d;

    // Synchroniser resets to the idle pin value so an untouched key raises no event after reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= {2{IDLE_RAW}};
      end else begin
        sync_q <= {sync_q[0], key_in[g]};
      end
    end

    assign key_sync = sync_q[1] ^ IDLE_RAW;

    // The window counts consecutive cycles of disagreement; any agreement restarts it.
    always_comb begin
      db_cnt_d  = db_cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (key_sync == level_q) begin
        db_cnt_d = '0;
      end else if (db_cnt_q == DB_LAST) begin
        db_cnt_d  = '0;
        level_d   = key_sync;
        press_d   = key_sync;
        release_d = ~key_sync;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        db_cnt_q  <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        db_cnt_q  <= db_cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    assign key_level[g]   = level_q;
    assign key_press[g]   = press_q;
    assign key_release[g] = release_q;

    if (LONG_CYCLES > 0) begin : g_long
      localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CYCLES);
      localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

      logic [LONG_W-1:0] hold_cnt_q, hold_cnt_d;
      logic              long_q, long_d;

      // A release decided on this edge wins over a long-press on the same edge.
      // Saturating at LONG_MAX makes the pulse fire at most once per press.
      always_comb begin
        hold_cnt_d = hold_cnt_q;
        long_d     = 1'b0;
        if (!level_q || release_d) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q != LONG_MAX) begin
          hold_cnt_d = hold_cnt_q + LONG_W'(1);
          long_d     = (hold_cnt_q == LONG_LAST);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hold_cnt_q <= '0;
          long_q     <= 1'b0;
        end else begin
          hold_cnt_q <= hold_cnt_d;
          long_q     <= long_d;
        end
      end

      assign key_long[g] = long_q;
    end else begin : g_no_long
      assign key_long[g] = 1'b0;
    end
  end

endmodule
